// File: rtl/pc_fetch_unit.sv
// Fetch program counter with stall, aligned branch redirect and a post-redirect bubble window.
// Also provides pc+INC / pc+2*INC and a saturating count of accepted redirects.
module pc_fetch_unit #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned       INC          = 4,
  parameter int unsigned       ALIGN_BITS   = 2,
  parameter int unsigned       FLUSH_CYCLES = 2,
  parameter int unsigned       CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch_en,
  input  logic [WIDTH-1:0]     branch_target,
  output logic [WIDTH-1:0]     pc,
  output logic [WIDTH-1:0]     pc_plus_inc,
  output logic [WIDTH-1:0]     pc_plus_2inc,
  output logic                 fetch_valid,
  output logic                 flushing,
  output logic [CNT_WIDTH-1:0] redirect_cnt
);

  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
  localparam logic [WIDTH-1:0] INC2_W     = WIDTH'(2 * INC);
  localparam logic [WIDTH-1:0] ALIGN_MASK = {WIDTH{1'b1}} << ALIGN_BITS;
  localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                 state_reg;
  logic [WIDTH-1:0]       pc_reg;
  logic [3:0]             flush_cnt_reg;
  logic [CNT_WIDTH-1:0]   redirect_cnt_reg;
  logic                   fetch_valid_reg;
  logic                   flushing_reg;

  logic [WIDTH-1:0]       aligned_target;
  logic [CNT_WIDTH-1:0]   redirect_cnt_next;

  assign aligned_target    = branch_target & ALIGN_MASK;
  assign redirect_cnt_next = (&redirect_cnt_reg) ? redirect_cnt_reg
                                                 : redirect_cnt_reg + 1'b1;

  // Priority: reset, redirect, flush countdown, stall, increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= RUN;
      pc_reg           <= RESET_VECTOR;
      flush_cnt_reg    <= '0;
      redirect_cnt_reg <= '0;
      fetch_valid_reg  <= 1'b1;
      flushing_reg     <= 1'b0;
    end else if (branch_en) begin
      pc_reg           <= aligned_target;
      redirect_cnt_reg <= redirect_cnt_next;
      if (FLUSH_CYCLES > 0) begin
        state_reg       <= FLUSH;
        flush_cnt_reg   <= FLUSH_INIT;
        fetch_valid_reg <= 1'b0;
        flushing_reg    <= 1'b1;
      end else begin
        state_reg       <= RUN;
        flush_cnt_reg   <= '0;
        fetch_valid_reg <= 1'b1;
        flushing_reg    <= 1'b0;
      end
    end else if (state_reg == FLUSH) begin
      // Countdown ignores stall; the target itself is fetched once it expires.
      flush_cnt_reg <= flush_cnt_reg - 1'b1;
      if (flush_cnt_reg <= 4'd1) begin
        state_reg       <= RUN;
        fetch_valid_reg <= 1'b1;
        flushing_reg    <= 1'b0;
      end
    end else if (!stall) begin
      pc_reg <= pc_reg + INC_W;
    end
  end

  assign pc           = pc_reg;
  assign pc_plus_inc  = pc_reg + INC_W;
  assign pc_plus_2inc = pc_reg + INC2_W;
  assign fetch_valid  = fetch_valid_reg;
  assign flushing     = flushing_reg;
  assign redirect_cnt = redirect_cnt_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench: directed steps push expected post-edge state, per-DUT monitors pop and compare.
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        fv;
    logic [15:0] cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int checks   = 0;
  int failures = 0;

  // DUT A: default parameters
  logic        rst_a = 1'b1, stall_a = 1'b0, br_a = 1'b0;
  logic [31:0] tgt_a = '0;
  logic [31:0] pc_a, pinc_a, p2inc_a;
  logic        fv_a, fl_a;
  logic [15:0] cnt_a;

  pc_fetch_unit dut_a (
    .clk(clk), .rst(rst_a), .stall(stall_a), .branch_en(br_a), .branch_target(tgt_a),
    .pc(pc_a), .pc_plus_inc(pinc_a), .pc_plus_2inc(p2inc_a),
    .fetch_valid(fv_a), .flushing(fl_a), .redirect_cnt(cnt_a)
  );

  // DUT B: wrapping reset vector, 2-bit saturating counter
  logic        rst_b = 1'b1, stall_b = 1'b0, br_b = 1'b0;
  logic [31:0] tgt_b = '0;
  logic [31:0] pc_b, pinc_b, p2inc_b;
  logic        fv_b, fl_b;
  logic [1:0]  cnt_b;

  pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst_b), .stall(stall_b), .branch_en(br_b), .branch_target(tgt_b),
    .pc(pc_b), .pc_plus_inc(pinc_b), .pc_plus_2inc(p2inc_b),
    .fetch_valid(fv_b), .flushing(fl_b), .redirect_cnt(cnt_b)
  );

  task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s: got %h expected %h", nm, field, act, exp);
    end
  endtask

  task automatic compare(input exp_t e, input logic [31:0] p, input logic [31:0] pi,
                         input logic [31:0] p2, input logic fv, input logic fl, input logic [15:0] c);
    chk(e.name, "pc", p, e.pc);
    chk(e.name, "pc_plus_inc", pi, e.pc + 32'd4);
    chk(e.name, "pc_plus_2inc", p2, e.pc + 32'd8);
    chk(e.name, "fetch_valid", {31'b0, fv}, {31'b0, e.fv});
    chk(e.name, "flushing", {31'b0, fl}, {31'b0, ~e.fv});
    chk(e.name, "redirect_cnt", {16'b0, c}, {16'b0, e.cnt});
    $display("txn %s: pc=%h fv=%0b cnt=%0d", e.name, p, fv, c);
  endtask

  initial begin : mon_a
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        compare(e, pc_a, pinc_a, p2inc_a, fv_a, fl_a, cnt_a);
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qb.size() > 0) begin
        e = qb.pop_front();
        compare(e, pc_b, pinc_b, p2inc_b, fv_b, fl_b, {14'b0, cnt_b});
      end
    end
  end

  task automatic step_a(input logic r, input logic s, input logic b, input logic [31:0] t,
                        input logic [31:0] epc, input logic efv, input logic [15:0] ecnt, input string nm);
    exp_t e;
    @(negedge clk);
    rst_a = r; stall_a = s; br_a = b; tgt_a = t;
    e.name = nm; e.pc = epc; e.fv = efv; e.cnt = ecnt;
    qa.push_back(e);
  endtask

  task automatic step_b(input logic r, input logic s, input logic b, input logic [31:0] t,
                        input logic [31:0] epc, input logic efv, input logic [15:0] ecnt, input string nm);
    exp_t e;
    @(negedge clk);
    rst_b = r; stall_b = s; br_b = b; tgt_b = t;
    e.name = nm; e.pc = epc; e.fv = efv; e.cnt = ecnt;
    qb.push_back(e);
  endtask

  initial begin
    // free-running increment after reset
    step_a(1, 0, 0, 32'h0,   32'h0,   1, 0, "a_reset");
    step_a(0, 0, 0, 32'h0,   32'h4,   1, 0, "a_inc1");
    step_a(0, 0, 0, 32'h0,   32'h8,   1, 0, "a_inc2");
    step_a(0, 0, 0, 32'h0,   32'hC,   1, 0, "a_inc3");
    // redirect with alignment and two bubbles
    step_a(0, 0, 1, 32'h57,  32'h54,  0, 1, "a_br57");
    step_a(0, 0, 0, 32'h0,   32'h54,  0, 1, "a_bub2");
    step_a(0, 0, 0, 32'h0,   32'h54,  1, 1, "a_tgt54");
    step_a(0, 0, 0, 32'h0,   32'h58,  1, 1, "a_inc58");
    // stall during flush does not extend it
    step_a(0, 0, 1, 32'h20,  32'h20,  0, 2, "a_br20");
    step_a(0, 1, 0, 32'h0,   32'h20,  0, 2, "a_flstall1");
    step_a(0, 1, 0, 32'h0,   32'h20,  1, 2, "a_flstall2");
    // stall in RUN holds pc
    step_a(0, 1, 0, 32'h0,   32'h20,  1, 2, "a_stall1");
    step_a(0, 1, 0, 32'h0,   32'h20,  1, 2, "a_stall2");
    step_a(0, 1, 0, 32'h0,   32'h20,  1, 2, "a_stall3");
    step_a(0, 0, 0, 32'h0,   32'h24,  1, 2, "a_release");
    // branch inside a flush restarts the bubble window
    step_a(0, 0, 1, 32'h80,  32'h80,  0, 3, "a_br80");
    step_a(0, 0, 1, 32'h100, 32'h100, 0, 4, "a_br100");
    step_a(0, 0, 0, 32'h0,   32'h100, 0, 4, "a_bub100");
    step_a(0, 0, 0, 32'h0,   32'h100, 1, 4, "a_tgt100");
    step_a(0, 0, 0, 32'h0,   32'h104, 1, 4, "a_inc104");
    // branch beats stall
    step_a(0, 1, 1, 32'h203, 32'h200, 0, 5, "a_brstall");
    step_a(0, 0, 0, 32'h0,   32'h200, 0, 5, "a_bub200");
    step_a(0, 0, 0, 32'h0,   32'h200, 1, 5, "a_tgt200");
    // reset mid-flush
    step_a(0, 0, 1, 32'h300, 32'h300, 0, 6, "a_br300");
    step_a(1, 0, 1, 32'h400, 32'h0,   1, 0, "a_rstflush");
    step_a(0, 0, 0, 32'h0,   32'h4,   1, 0, "a_postrst");

    // wrap-around from a high reset vector
    step_b(1, 0, 0, 32'h0,   32'hFFFF_FFF8, 1, 0, "b_reset");
    step_b(0, 0, 0, 32'h0,   32'hFFFF_FFFC, 1, 0, "b_inc1");
    step_b(0, 0, 0, 32'h0,   32'h0,         1, 0, "b_wrap");
    // 2-bit redirect counter saturates at 3
    step_b(0, 0, 1, 32'h10,  32'h10,        0, 1, "b_br1");
    step_b(0, 0, 1, 32'h21,  32'h20,        0, 2, "b_br2");
    step_b(0, 0, 1, 32'h32,  32'h30,        0, 3, "b_br3");
    step_b(0, 0, 1, 32'h43,  32'h40,        0, 3, "b_br4");
    step_b(0, 0, 1, 32'h54,  32'h54,        0, 3, "b_br5");
    step_b(0, 0, 0, 32'h0,   32'h54,        0, 3, "b_bub");
    step_b(0, 0, 0, 32'h0,   32'h54,        1, 3, "b_tgt");
    step_b(0, 0, 0, 32'h0,   32'h58,        1, 3, "b_inc");

    @(negedge clk);
    @(negedge clk);
    chk("drain", "pending", 32'(qa.size() + qb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
